// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display: segment bit order and
// active-high glyph patterns (gfedcba) for BCD digits 0-9 plus blank.
package disp_pkg;

  localparam int unsigned SegW = 7;

  localparam int unsigned SegA = 0;
  localparam int unsigned SegB = 1;
  localparam int unsigned SegC = 2;
  localparam int unsigned SegD = 3;
  localparam int unsigned SegE = 4;
  localparam int unsigned SegF = 5;
  localparam int unsigned SegG = 6;

  localparam logic [SegW-1:0] Seg0     = 7'h3F;
  localparam logic [SegW-1:0] Seg1     = 7'h06;
  localparam logic [SegW-1:0] Seg2     = 7'h5B;
  localparam logic [SegW-1:0] Seg3     = 7'h4F;
  localparam logic [SegW-1:0] Seg4     = 7'h66;
  localparam logic [SegW-1:0] Seg5     = 7'h6D;
  localparam logic [SegW-1:0] Seg6     = 7'h7D;
  localparam logic [SegW-1:0] Seg7     = 7'h07;
  localparam logic [SegW-1:0] Seg8     = 7'h7F;
  localparam logic [SegW-1:0] Seg9     = 7'h6F;
  localparam logic [SegW-1:0] SegBlank = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-high 7-segment decoder; non-BCD codes A-F blank the digit.
module bcd_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0]      bcd,
  output logic [SegW-1:0] seg
);

  always_comb begin
    seg = SegBlank;
    case (bcd)
      4'd0:    seg = Seg0;
      4'd1:    seg = Seg1;
      4'd2:    seg = Seg2;
      4'd3:    seg = Seg3;
      4'd4:    seg = Seg4;
      4'd5:    seg = Seg5;
      4'd6:    seg = Seg6;
      4'd7:    seg = Seg7;
      4'd8:    seg = Seg8;
      4'd9:    seg = Seg9;
      default: seg = SegBlank;
    endcase
  end

endmodule

// File: rtl/mux_display_7seg.sv
// Multiplexed N-digit 7-segment driver: per-frame tear-free snapshot, anode scan with an
// all-off guard at the start of each slot, per-digit blink and decimal points.
module mux_display_7seg
  import disp_pkg::*;
#(
  parameter int unsigned N_DIG        = 6,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned GUARD        = 4,
  parameter int unsigned BLINK_FRAMES = 128,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4*N_DIG-1:0] digits_in,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   blink_mask,
  input  logic               en,
  output logic [N_DIG-1:0]   an,
  output logic [SegW-1:0]    seg,
  output logic               dp,
  output logic               frame_tick
);

  localparam int unsigned SlotW  = $clog2(PRESCALE);
  localparam int unsigned IdxW   = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SlotW-1:0]       slot_cnt_q, slot_cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [BlinkW-1:0]      blink_cnt_q, blink_cnt_d;
  logic                   blink_phase_q, blink_phase_d;
  logic [N_DIG-1:0][3:0]  digit_snap_q;
  logic [N_DIG-1:0]       dp_snap_q;
  logic [N_DIG-1:0]       blink_snap_q;
  logic [N_DIG-1:0]       an_q, an_d;
  logic [SegW-1:0]        seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic                   frame_tick_q;

  logic                   slot_wrap;
  logic                   idx_last;
  logic                   frame_end;
  logic                   an_on;
  logic [N_DIG-1:0]       an_hi;
  logic [SegW-1:0]        cur_seg;

  bcd_to_7seg u_bcd_to_7seg (
    .bcd (digit_snap_q[idx_q]),
    .seg (cur_seg)
  );

  always_comb begin
    slot_wrap     = (slot_cnt_q == SlotW'(PRESCALE - 1));
    idx_last      = (idx_q == IdxW'(N_DIG - 1));
    frame_end     = slot_wrap && idx_last;

    slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    idx_d         = idx_q;
    if (slot_wrap) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Output stage sees the current scan state; results appear one cycle later.
  always_comb begin
    an_on = en && (slot_cnt_q >= SlotW'(GUARD)) && !(blink_phase_q && blink_snap_q[idx_q]);
    an_hi = '0;
    if (an_on) begin
      an_hi[idx_q] = 1'b1;
    end
    an_d  = an_hi ^ {N_DIG{ACTIVE_LOW}};
    seg_d = (an_on ? cur_seg : SegBlank) ^ {SegW{ACTIVE_LOW}};
    dp_d  = (an_on & dp_snap_q[idx_q]) ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      digit_snap_q  <= '0;
      dp_snap_q     <= '0;
      blink_snap_q  <= '0;
      an_q          <= {N_DIG{ACTIVE_LOW}};
      seg_q         <= {SegW{ACTIVE_LOW}};
      dp_q          <= ACTIVE_LOW;
      frame_tick_q  <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      if (frame_end) begin
        digit_snap_q <= digits_in;
        dp_snap_q    <= dp_in;
        blink_snap_q <= blink_mask;
      end
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_tick_q  <= frame_end;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
